mdu_alu_control: RTL and testbench

MDU_ALU_CONTROL -- requirements
Module: mdu_alu_control

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_alu_control_if.sv | 28 ++
 rtl/mdu_iter_core.sv | 61 ++++++
 rtl/mdu_alu_control.sv | 147 ++++++++++++++
 tb/tb_mdu_alu_control.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the ALU control / multiply-divide unit.
package mdu_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_AND   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_XOR   = 3'b100;
  localparam logic [2:0] ALUOP_LUI   = 3'b101;
  localparam logic [2:0] ALUOP_SUBU  = 3'b110;
  localparam logic [2:0] ALUOP_SLT   = 3'b111;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [5:0] SEL_ADD  = 6'b100000;
  localparam logic [5:0] SEL_AND  = 6'b100100;
  localparam logic [5:0] SEL_OR   = 6'b100101;
  localparam logic [5:0] SEL_XOR  = 6'b100110;
  localparam logic [5:0] SEL_LUI  = 6'b110110;
  localparam logic [5:0] SEL_SUBU = 6'b100011;
  localparam logic [5:0] SEL_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // MULT/MULTU/DIV/DIVU share the 0110xx prefix: bit 1 selects divide, bit 0 unsigned.
  function automatic logic is_mdu_op(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mdu_alu_control_if.sv
// EX-stage bus between the pipeline and the ALU control / MDU block.
interface mdu_alu_control_if #(
  parameter int ALU_OP = 3,
  parameter int FUNCT  = 6,
  parameter int DATA_W = 32
);
  logic              i_valid_E;
  logic [ALU_OP-1:0] i_alu_op_MC;
  logic [FUNCT-1:0]  i_instr_funct_E;
  logic [DATA_W-1:0] i_rs_data;
  logic [DATA_W-1:0] i_rt_data;
  logic [FUNCT-1:0]  o_alu_sel_AC;
  logic              o_stall_MDU;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;
  logic              o_mdu_done;
  logic              o_div_by_zero;

  modport master (
    output i_valid_E, i_alu_op_MC, i_instr_funct_E, i_rs_data, i_rt_data,
    input  o_alu_sel_AC, o_stall_MDU, o_hi, o_lo, o_mdu_done, o_div_by_zero
  );

  modport slave (
    input  i_valid_E, i_alu_op_MC, i_instr_funct_E, i_rs_data, i_rt_data,
    output o_alu_sel_AC, o_stall_MDU, o_hi, o_lo, o_mdu_done, o_div_by_zero
  );
endinterface

// File: rtl/mdu_iter_core.sv
// Iterative unsigned datapath: one shift-add multiply or restoring-divide step per cycle.
// The accumulator holds {partial_hi, partial_lo} for multiply and {remainder, quotient} for divide.
module mdu_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                step,
  input  logic                is_div,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                last_step,
  output logic [2*DATA_W-1:0] acc_next
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0]   operand_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                div_reg;

  logic [DATA_W:0] add_sum;
  logic [DATA_W:0] sub_shift;
  logic [DATA_W:0] sub_diff;

  always_comb begin
    add_sum   = {1'b0, acc_reg[2*DATA_W-1:DATA_W]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    // Remainder shifted left with the next dividend bit brought in.
    sub_shift = acc_reg[2*DATA_W-1:DATA_W-1];
    sub_diff  = sub_shift - {1'b0, operand_reg};
    if (div_reg) begin
      if (!sub_diff[DATA_W])
        acc_next = {sub_diff[DATA_W-1:0], acc_reg[DATA_W-2:0], 1'b1};
      else
        acc_next = {sub_shift[DATA_W-1:0], acc_reg[DATA_W-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc_reg[DATA_W-1:1]};
    end
  end

  assign last_step = step && (count_reg == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      operand_reg <= '0;
      count_reg   <= '0;
      div_reg     <= 1'b0;
    end else if (start) begin
      acc_reg     <= {{DATA_W{1'b0}}, (is_div ? op_a : op_b)};
      operand_reg <= is_div ? op_b : op_a;
      count_reg   <= '0;
      div_reg     <= is_div;
    end else if (step) begin
      acc_reg     <= acc_next;
      count_reg   <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mdu_alu_control.sv
// ALU select decode plus multi-cycle multiply/divide control with HI/LO registers.
module mdu_alu_control
  import mdu_pkg::*;
#(
  parameter int ALU_OP = 3,
  parameter int FUNCT  = 6,
  parameter int DATA_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  mdu_alu_control_if.slave bus
);

  mdu_state_e state_reg, state_next;

  logic              div_reg, neg_a_reg, neg_b_reg, dz_reg;
  logic [DATA_W-1:0] hi_reg, lo_reg, hi_next, lo_next;

  logic [5:0]        funct;
  logic [DATA_W-1:0] rs, rt, mag_a, mag_b;
  logic              is_funct_op, issue, issue_div, issue_signed, div_zero;
  logic              mt_hi, mt_lo, leave_busy;

  logic                core_start, core_step, core_last;
  logic [2*DATA_W-1:0] core_acc_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  logic [FUNCT-1:0]    alu_sel;

  assign funct        = bus.i_instr_funct_E[5:0];
  assign rs           = bus.i_rs_data;
  assign rt           = bus.i_rt_data;
  assign is_funct_op  = bus.i_valid_E && (bus.i_alu_op_MC == ALU_OP'(ALUOP_FUNCT));
  assign issue        = (state_reg == ST_IDLE) && is_funct_op && is_mdu_op(funct);
  assign issue_div    = funct[1];
  assign issue_signed = !funct[0];
  assign div_zero     = issue && issue_div && (rt == '0);
  assign mt_hi        = (state_reg == ST_IDLE) && is_funct_op && (funct == FUNCT_MTHI);
  assign mt_lo        = (state_reg == ST_IDLE) && is_funct_op && (funct == FUNCT_MTLO);
  assign mag_a        = (issue_signed && rs[DATA_W-1]) ? -rs : rs;
  assign mag_b        = (issue_signed && rt[DATA_W-1]) ? -rt : rt;
  assign core_step    = (state_reg == ST_BUSY);
  assign leave_busy   = core_step && core_last;

  mdu_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .start     (core_start),
    .step      (core_step),
    .is_div    (issue_div),
    .op_a      (mag_a),
    .op_b      (mag_b),
    .last_step (core_last),
    .acc_next  (core_acc_next)
  );

  // Truncating signed divide: quotient negative on sign mismatch, remainder follows the dividend.
  assign prod_fix = (neg_a_reg ^ neg_b_reg) ? -core_acc_next : core_acc_next;
  assign quo_fix  = (neg_a_reg ^ neg_b_reg) ? -core_acc_next[DATA_W-1:0] : core_acc_next[DATA_W-1:0];
  assign rem_fix  = neg_a_reg ? -core_acc_next[2*DATA_W-1:DATA_W] : core_acc_next[2*DATA_W-1:DATA_W];

  always_comb begin
    state_next = state_reg;
    core_start = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (issue) begin
          if (div_zero) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_BUSY;
            core_start = 1'b1;
          end
        end
      end
      ST_BUSY: if (core_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (div_zero) begin
      hi_next = rs;
      lo_next = '1;
    end else if (leave_busy) begin
      if (div_reg) begin
        hi_next = rem_fix;
        lo_next = quo_fix;
      end else begin
        hi_next = prod_fix[2*DATA_W-1:DATA_W];
        lo_next = prod_fix[DATA_W-1:0];
      end
    end else begin
      if (mt_hi) hi_next = rs;
      if (mt_lo) lo_next = rs;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= ST_IDLE;
      div_reg   <= 1'b0;
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      dz_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      if (issue) begin
        div_reg   <= issue_div;
        neg_a_reg <= issue_signed && rs[DATA_W-1];
        neg_b_reg <= issue_signed && rt[DATA_W-1];
        dz_reg    <= div_zero;
      end
    end
  end

  always_comb begin
    alu_sel = FUNCT'(SEL_ADD);
    case (bus.i_alu_op_MC)
      ALU_OP'(ALUOP_FUNCT): alu_sel = bus.i_instr_funct_E;
      ALU_OP'(ALUOP_ADD):   alu_sel = FUNCT'(SEL_ADD);
      ALU_OP'(ALUOP_AND):   alu_sel = FUNCT'(SEL_AND);
      ALU_OP'(ALUOP_OR):    alu_sel = FUNCT'(SEL_OR);
      ALU_OP'(ALUOP_XOR):   alu_sel = FUNCT'(SEL_XOR);
      ALU_OP'(ALUOP_LUI):   alu_sel = FUNCT'(SEL_LUI);
      ALU_OP'(ALUOP_SUBU):  alu_sel = FUNCT'(SEL_SUBU);
      ALU_OP'(ALUOP_SLT):   alu_sel = FUNCT'(SEL_SLT);
      default:              alu_sel = FUNCT'(SEL_ADD);
    endcase
  end

  // Reset gating keeps stall low even while a MDU op sits on the inputs.
  assign bus.o_alu_sel_AC  = alu_sel;
  assign bus.o_stall_MDU   = i_reset_n && (issue || (state_reg == ST_BUSY));
  assign bus.o_mdu_done    = (state_reg == ST_DONE);
  assign bus.o_div_by_zero = (state_reg == ST_DONE) && dz_reg;
  assign bus.o_hi          = hi_reg;
  assign bus.o_lo          = lo_reg;

endmodule

// File: tb/tb_mdu_alu_control.sv
// Directed self-checking bench for mdu_alu_control (DATA_W=32).
module tb_mdu_alu_control;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic [5:0] exp_sel [8] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h26, 6'h36, 6'h23, 6'h2A};

  always #5 clk = ~clk;

  mdu_alu_control_if #(.ALU_OP(3), .FUNCT(6), .DATA_W(32)) bus ();

  mdu_alu_control #(.ALU_OP(3), .FUNCT(6), .DATA_W(32)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mt_write(input string tag, input logic [5:0] funct, input logic [31:0] val);
    bus.i_valid_E       = 1'b1;
    bus.i_alu_op_MC     = 3'b010;
    bus.i_instr_funct_E = funct;
    bus.i_rs_data       = val;
    @(negedge clk);
    check({tag, "_stall"}, bus.o_stall_MDU, 1'b0);
    step();
    bus.i_valid_E = 1'b0;
    if (funct == F_MTHI) model_hi = val;
    else model_lo = val;
    @(negedge clk);
    check({tag, "_hi"}, bus.o_hi, model_hi);
    check({tag, "_lo"}, bus.o_lo, model_lo);
    $display("mt   %s val=0x%08h -> hi=0x%08h lo=0x%08h", tag, val, bus.o_hi, bus.o_lo);
    step();
  endtask

  task automatic run_mdu(input string tag, input logic [5:0] funct, input logic [31:0] rs,
                         input logic [31:0] rt, input int exp_stall, input logic exp_dz,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stalls;
    stalls = 0;
    bus.i_valid_E       = 1'b1;
    bus.i_alu_op_MC     = 3'b010;
    bus.i_instr_funct_E = funct;
    bus.i_rs_data       = rs;
    bus.i_rt_data       = rt;
    @(negedge clk);
    while (bus.o_stall_MDU && stalls < 100) begin
      stalls++;
      if (stalls == 2) begin
        check({tag, "_busy_hi"}, bus.o_hi, model_hi);
        check({tag, "_busy_lo"}, bus.o_lo, model_lo);
      end
      @(negedge clk);
    end
    check({tag, "_stalls"}, stalls, exp_stall);
    check({tag, "_done"}, bus.o_mdu_done, 1'b1);
    check({tag, "_dz"}, bus.o_div_by_zero, exp_dz);
    // Pipeline advances out of DONE; next instruction reads LO.
    step();
    bus.i_instr_funct_E = F_MFLO;
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.o_mdu_done, 1'b0);
    check({tag, "_mflo_stall"}, bus.o_stall_MDU, 1'b0);
    check({tag, "_hi"}, bus.o_hi, exp_hi);
    check({tag, "_mflo_lo"}, bus.o_lo, exp_lo);
    $display("mdu  %s rs=0x%08h rt=0x%08h -> hi=0x%08h lo=0x%08h stalls=%0d",
             tag, rs, rt, bus.o_hi, bus.o_lo, stalls);
    step();
    bus.i_valid_E = 1'b0;
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    int done_cnt;
    // A MULT sits on the inputs during reset; nothing may respond.
    bus.i_valid_E       = 1'b1;
    bus.i_alu_op_MC     = 3'b010;
    bus.i_instr_funct_E = F_MULT;
    bus.i_rs_data       = 32'hDEAD;
    bus.i_rt_data       = 32'h5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", bus.o_stall_MDU, 1'b0);
    check("rst_hi", bus.o_hi, 32'h0);
    check("rst_lo", bus.o_lo, 32'h0);
    check("rst_done", bus.o_mdu_done, 1'b0);
    check("rst_dz", bus.o_div_by_zero, 1'b0);
    bus.i_valid_E = 1'b0;
    rst_n = 1'b1;
    step();

    bus.i_instr_funct_E = 6'h21;
    for (int i = 0; i < 8; i++) begin
      bus.i_alu_op_MC = 3'(i);
      #1;
      check($sformatf("alu_sel_op%0d", i), bus.o_alu_sel_AC, exp_sel[i]);
    end
    step();

    mt_write("mthi", F_MTHI, 32'h1234);
    mt_write("mtlo", F_MTLO, 32'h5678);

    run_mdu("mult",    F_MULT,  32'hFFFFFFFD, 32'd7,        33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_mdu("multu",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_mdu("div_neg", F_DIV,   32'hFFFFFFF9, 32'd2,        33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_mdu("div_min", F_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 1'b0, 32'h00000000, 32'h80000000);
    run_mdu("divu",    F_DIVU,  32'd100,      32'd7,        33, 1'b0, 32'h00000002, 32'h0000000E);
    run_mdu("divu_z",  F_DIVU,  32'd100,      32'd0,         1, 1'b1, 32'h00000064, 32'hFFFFFFFF);

    // Abort a MULT at BUSY cycle 10.
    mt_write("mthi11", F_MTHI, 32'h11);
    bus.i_valid_E       = 1'b1;
    bus.i_alu_op_MC     = 3'b010;
    bus.i_instr_funct_E = F_MULT;
    bus.i_rs_data       = 32'd5;
    bus.i_rt_data       = 32'd6;
    @(negedge clk);
    check("abort_issue_stall", bus.o_stall_MDU, 1'b1);
    repeat (10) step();
    @(negedge clk);
    check("abort_busy10_stall", bus.o_stall_MDU, 1'b1);
    check("abort_busy10_hi", bus.o_hi, 32'h11);
    rst_n = 1'b0;
    #1;
    check("abort_stall", bus.o_stall_MDU, 1'b0);
    check("abort_hi", bus.o_hi, 32'h0);
    check("abort_lo", bus.o_lo, 32'h0);
    step();
    step();
    bus.i_valid_E = 1'b0;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_mdu_done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_post_hi", bus.o_hi, 32'h0);
    check("abort_post_lo", bus.o_lo, 32'h0);
    $display("rst  abort mult at busy cycle 10 -> hi=0x%08h lo=0x%08h done_pulses=%0d",
             bus.o_hi, bus.o_lo, done_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
